// File: rtl/id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_operand_stage
// Description : ID/EX register ahead of the ALU: operand capture, ALU op
//               decode, EX/MEM and MEM/WB forwarding, immediate select.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_operand_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [2:0]        id_funct3,
  input  logic              id_funct7b5,
  input  logic              id_is_rtype,
  input  logic              id_alu_src,
  input  logic              id_reg_write,
  input  logic              flush,
  input  logic              ex_ready,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [XLEN-1:0]   exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [XLEN-1:0]   memwb_result,
  output logic [XLEN-1:0]   in1,
  output logic [XLEN-1:0]   in2,
  output logic [3:0]        alu_control,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              illegal_op
);

  localparam logic [3:0] C_ALU_ADD = 4'b0000;
  localparam logic [3:0] C_ALU_SUB = 4'b0001;
  localparam logic [3:0] C_ALU_AND = 4'b0010;
  localparam logic [3:0] C_ALU_OR  = 4'b0100;
  localparam logic [3:0] C_ALU_SLT = 4'b1000;

  logic              ex_valid_q;
  logic              ex_reg_write_q;
  logic [REG_AW-1:0] ex_rd_q;
  logic [REG_AW-1:0] rs1_q;
  logic [REG_AW-1:0] rs2_q;
  logic [XLEN-1:0]   rs1_data_q;
  logic [XLEN-1:0]   rs2_data_q;
  logic [XLEN-1:0]   imm_q;
  logic              alu_src_q;
  logic [3:0]        alu_ctl_q;
  logic              illegal_q;

  logic [3:0]        alu_ctl_d;
  logic              illegal_d;
  logic [XLEN-1:0]   rs1_data_d;
  logic [XLEN-1:0]   rs2_data_d;
  logic [XLEN-1:0]   fwd1;
  logic [XLEN-1:0]   fwd2;
  logic              capture;
  logic              hold;

  assign id_ready = !ex_valid_q || ex_ready;
  assign capture  = id_valid && id_ready;
  assign hold     = ex_valid_q && !ex_ready;

  always_comb begin
    alu_ctl_d = C_ALU_ADD;
    illegal_d = 1'b0;
    case (id_funct3)
      3'b000: alu_ctl_d = (id_is_rtype && id_funct7b5) ? C_ALU_SUB : C_ALU_ADD;
      3'b111: alu_ctl_d = C_ALU_AND;
      3'b110: alu_ctl_d = C_ALU_OR;
      3'b010: alu_ctl_d = C_ALU_SLT;
      default: illegal_d = 1'b1;
    endcase
    // bit 30 only selects SUB; on any other R-type op it marks an unsupported encoding
    if (id_funct3 != 3'b000 && id_is_rtype && id_funct7b5) begin
      illegal_d = 1'b1;
    end
    if (illegal_d) begin
      alu_ctl_d = C_ALU_ADD;
    end
  end

  assign rs1_data_d = (id_rs1 == '0) ? '0 : id_rs1_data;
  assign rs2_data_d = (id_rs2 == '0) ? '0 : id_rs2_data;

  // EX/MEM outranks MEM/WB because it holds the younger result for the same index
  always_comb begin
    fwd1 = rs1_data_q;
    if (exmem_reg_write && exmem_rd == rs1_q && rs1_q != '0) begin
      fwd1 = exmem_result;
    end else if (memwb_reg_write && memwb_rd == rs1_q && rs1_q != '0) begin
      fwd1 = memwb_result;
    end
  end

  always_comb begin
    fwd2 = rs2_data_q;
    if (exmem_reg_write && exmem_rd == rs2_q && rs2_q != '0) begin
      fwd2 = exmem_result;
    end else if (memwb_reg_write && memwb_rd == rs2_q && rs2_q != '0) begin
      fwd2 = memwb_result;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q     <= 1'b0;
      ex_reg_write_q <= 1'b0;
      ex_rd_q        <= '0;
      rs1_q          <= '0;
      rs2_q          <= '0;
      rs1_data_q     <= '0;
      rs2_data_q     <= '0;
      imm_q          <= '0;
      alu_src_q      <= 1'b0;
      alu_ctl_q      <= C_ALU_ADD;
      illegal_q      <= 1'b0;
    end else if (flush) begin
      ex_valid_q     <= 1'b0;
      ex_reg_write_q <= 1'b0;
      illegal_q      <= 1'b0;
    end else if (capture) begin
      ex_valid_q     <= 1'b1;
      ex_reg_write_q <= id_reg_write;
      ex_rd_q        <= id_rd;
      rs1_q          <= id_rs1;
      rs2_q          <= id_rs2;
      rs1_data_q     <= rs1_data_d;
      rs2_data_q     <= rs2_data_d;
      imm_q          <= id_imm;
      alu_src_q      <= id_alu_src;
      alu_ctl_q      <= alu_ctl_d;
      illegal_q      <= illegal_d;
    end else if (hold) begin
      // latch forwarded values so a producer that retires mid-stall is not lost
      rs1_data_q     <= fwd1;
      rs2_data_q     <= fwd2;
    end else begin
      ex_valid_q     <= 1'b0;
      ex_reg_write_q <= 1'b0;
    end
  end

  assign in1          = fwd1;
  assign in2          = alu_src_q ? imm_q : fwd2;
  assign alu_control  = alu_ctl_q;
  assign ex_valid     = ex_valid_q;
  assign ex_rd        = ex_rd_q;
  assign ex_reg_write = ex_reg_write_q;
  assign illegal_op   = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_operand_stage
// Description : Directed self-checking bench for id_ex_operand_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_operand_stage;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_rs1_data;
  logic [31:0] id_rs2_data;
  logic [31:0] id_imm;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic [2:0]  id_funct3;
  logic        id_funct7b5;
  logic        id_is_rtype;
  logic        id_alu_src;
  logic        id_reg_write;
  logic        flush;
  logic        ex_ready;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_result;
  logic [31:0] in1;
  logic [31:0] in2;
  logic [3:0]  alu_control;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        illegal_op;

  int errors = 0;
  int checks = 0;

  id_ex_operand_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_funct3(id_funct3), .id_funct7b5(id_funct7b5), .id_is_rtype(id_is_rtype),
    .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
    .flush(flush), .ex_ready(ex_ready),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .in1(in1), .in2(in2), .alu_control(alu_control),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_fwd();
    exmem_reg_write = 1'b0; exmem_rd = '0; exmem_result = '0;
    memwb_reg_write = 1'b0; memwb_rd = '0; memwb_result = '0;
  endtask

  task automatic drive_instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                             input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                             input logic [2:0] f3, input logic f7, input logic rtype,
                             input logic src, input logic wr);
    id_valid = 1'b1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
    id_funct3 = f3; id_funct7b5 = f7; id_is_rtype = rtype;
    id_alu_src = src; id_reg_write = wr;
  endtask

  // Inputs change and outputs are sampled 2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid: got %0h want 0", ex_valid); end
    checks++; if (ex_reg_write !== 1'b0) begin errors++; $display("FAIL reset_ex_reg_write: got %0h want 0", ex_reg_write); end
    checks++; if (ex_rd !== 5'd0) begin errors++; $display("FAIL reset_ex_rd: got %0d want 0", ex_rd); end
    checks++; if (alu_control !== 4'b0000) begin errors++; $display("FAIL reset_alu_control: got %b want 0000", alu_control); end
    checks++; if (illegal_op !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %0h want 0", illegal_op); end
    checks++; if (in1 !== 32'd0 || in2 !== 32'd0) begin errors++; $display("FAIL reset_operands: got in1=%0h in2=%0h want 0/0", in1, in2); end
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL reset_id_ready: got %0h want 1", id_ready); end
  endtask

  task automatic test_add();
    drive_instr(5'd5, 5'd7, 5'd3, 32'd23, 32'd42, 32'd0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %0h want 1", ex_valid); end
    checks++; if (in1 !== 32'd23 || in2 !== 32'd42) begin errors++; $display("FAIL add_operands: got in1=%0d in2=%0d want 23/42", in1, in2); end
    checks++; if (alu_control !== 4'b0000) begin errors++; $display("FAIL add_ctl: got %b want 0000", alu_control); end
    checks++; if (ex_rd !== 5'd3 || ex_reg_write !== 1'b1) begin errors++; $display("FAIL add_rd: got rd=%0d wr=%0h want 3/1", ex_rd, ex_reg_write); end
    id_valid = 1'b0;
    tick();
    checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin errors++; $display("FAIL bubble: got valid=%0h wr=%0h want 0/0", ex_valid, ex_reg_write); end
  endtask

  task automatic test_forward_priority();
    drive_instr(5'd1, 5'd2, 5'd4, 32'd11, 32'd22, 32'd0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    id_valid = 1'b0;
    exmem_reg_write = 1'b1; exmem_rd = 5'd1; exmem_result = 32'd100;
    memwb_reg_write = 1'b1; memwb_rd = 5'd1; memwb_result = 32'd55;
    #1;
    checks++; if (in1 !== 32'd100) begin errors++; $display("FAIL fwd_exmem_prio: got %0d want 100", in1); end
    checks++; if (alu_control !== 4'b0001) begin errors++; $display("FAIL sub_ctl: got %b want 0001", alu_control); end
    exmem_reg_write = 1'b0;
    #1;
    checks++; if (in1 !== 32'd55) begin errors++; $display("FAIL fwd_memwb: got %0d want 55", in1); end
    memwb_rd = 5'd2;
    #1;
    checks++; if (in1 !== 32'd11 || in2 !== 32'd55) begin errors++; $display("FAIL fwd_rs2: got in1=%0d in2=%0d want 11/55", in1, in2); end
    clear_fwd();
    #1;
    checks++; if (in2 !== 32'd22) begin errors++; $display("FAIL fwd_none: got %0d want 22", in2); end
  endtask

  task automatic test_x0();
    drive_instr(5'd0, 5'd0, 5'd8, 32'd77, 32'd88, 32'd0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1);
    exmem_reg_write = 1'b1; exmem_rd = 5'd0; exmem_result = 32'd99;
    tick();
    id_valid = 1'b0;
    #1;
    checks++; if (in1 !== 32'd0 || in2 !== 32'd0) begin errors++; $display("FAIL x0_no_fwd: got in1=%0d in2=%0d want 0/0", in1, in2); end
    clear_fwd();
  endtask

  task automatic test_imm_ops();
    logic [2:0] f3_tab [3];
    logic [3:0] ctl_tab [3];
    f3_tab[0] = 3'b111; ctl_tab[0] = 4'b0010;
    f3_tab[1] = 3'b110; ctl_tab[1] = 4'b0100;
    f3_tab[2] = 3'b010; ctl_tab[2] = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      drive_instr(5'd9, 5'd10, 5'd11, 32'd5, 32'd6, 32'hFFFF_FFF0 + i, f3_tab[i], 1'b1, 1'b0, 1'b1, 1'b1);
      tick();
      checks++;
      if (alu_control !== ctl_tab[i] || illegal_op !== 1'b0 || in2 !== 32'hFFFF_FFF0 + i || in1 !== 32'd5) begin
        errors++;
        $display("FAIL imm_op%0d: got ctl=%b ill=%0h in1=%0h in2=%0h want %b/0/5/%0h",
                 i, alu_control, illegal_op, in1, in2, ctl_tab[i], 32'hFFFF_FFF0 + i);
      end
    end
    drive_instr(5'd9, 5'd10, 5'd11, 32'd5, 32'd6, 32'd0, 3'b111, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    checks++; if (illegal_op !== 1'b1 || alu_control !== 4'b0000) begin errors++; $display("FAIL rtype_and_f7: got ill=%0h ctl=%b want 1/0000", illegal_op, alu_control); end
    id_valid = 1'b0;
    tick();
  endtask

  task automatic test_stall_refresh();
    drive_instr(5'd4, 5'd0, 5'd12, 32'd10, 32'd0, 32'd0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    drive_instr(5'd6, 5'd0, 5'd9, 32'd1, 32'd0, 32'd0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1);
    ex_ready = 1'b0;
    exmem_reg_write = 1'b1; exmem_rd = 5'd4; exmem_result = 32'd500;
    #1;
    checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL stall_id_ready: got %0h want 0", id_ready); end
    tick();
    clear_fwd();
    #1;
    checks++; if (in1 !== 32'd500) begin errors++; $display("FAIL stall_refresh: got %0d want 500", in1); end
    tick();
    tick();
    checks++; if (in1 !== 32'd500 || ex_rd !== 5'd12 || ex_valid !== 1'b1) begin errors++; $display("FAIL stall_hold: got in1=%0d rd=%0d v=%0h want 500/12/1", in1, ex_rd, ex_valid); end
    ex_ready = 1'b1;
    #1;
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %0h want 1", id_ready); end
    tick();
    checks++; if (ex_rd !== 5'd9 || in1 !== 32'd1) begin errors++; $display("FAIL stall_next_capture: got rd=%0d in1=%0d want 9/1", ex_rd, in1); end
    id_valid = 1'b0;
    tick();
  endtask

  task automatic test_illegal_flush();
    drive_instr(5'd1, 5'd2, 5'd5, 32'd3, 32'd4, 32'd0, 3'b001, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    checks++; if (illegal_op !== 1'b1 || alu_control !== 4'b0000 || ex_valid !== 1'b1) begin errors++; $display("FAIL illegal_f3: got ill=%0h ctl=%b v=%0h want 1/0000/1", illegal_op, alu_control, ex_valid); end
    drive_instr(5'd1, 5'd2, 5'd7, 32'd3, 32'd4, 32'd0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1);
    flush = 1'b1;
    ex_ready = 1'b0;
    #1;
    checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL flush_id_ready: got %0h want 0", id_ready); end
    ex_ready = 1'b1;
    tick();
    checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || illegal_op !== 1'b0) begin errors++; $display("FAIL flush: got v=%0h wr=%0h ill=%0h want 0/0/0", ex_valid, ex_reg_write, illegal_op); end
    flush = 1'b0;
    id_valid = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    drive_instr(5'd3, 5'd4, 5'd6, 32'd30, 32'd40, 32'd0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    id_valid = 1'b0;
    ex_ready = 1'b0;
    #1;
    checks++; if (ex_valid !== 1'b1 || ex_reg_write !== 1'b1) begin errors++; $display("FAIL pre_reset_hold: got v=%0h wr=%0h want 1/1", ex_valid, ex_reg_write); end
    rst = 1'b1;
    #1;
    checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_rd !== 5'd0 || in1 !== 32'd0) begin
      errors++; $display("FAIL async_reset: got v=%0h wr=%0h rd=%0d in1=%0d want 0/0/0/0", ex_valid, ex_reg_write, ex_rd, in1);
    end
    #1;
    rst = 1'b0;
    ex_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    id_valid = 1'b0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_funct3 = '0; id_funct7b5 = 1'b0;
    id_is_rtype = 1'b0; id_alu_src = 1'b0; id_reg_write = 1'b0;
    flush = 1'b0; ex_ready = 1'b1;
    clear_fwd();
    tick();
    tick();
    rst = 1'b0;
    #1;
    test_reset();
    test_add();
    test_forward_priority();
    test_x0();
    test_imm_ops();
    test_stall_refresh();
    test_illegal_flush();
    test_async_reset();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
